// File: rtl/rle_pkg.sv
// rle_pkg: shared widths, FSM state encoding and token type for the run-length encoder
package rle_pkg;
  localparam int SYM_W_DEF = 4;
  localparam int RUN_W_DEF = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;
  typedef struct packed {
    logic [SYM_W_DEF-1:0] sym;
    logic [RUN_W_DEF-1:0] run;
    logic                 last;
  } token_t;
  function automatic int run_max(input int run_w);
    return (1 << run_w) - 1;
  endfunction
endpackage

// File: rtl/rle_stream_encoder_if.sv
// rle_stream_encoder_if: input code stream and output token stream handshakes
interface rle_stream_encoder_if import rle_pkg::*; #(
  parameter int SYM_W = SYM_W_DEF,
  parameter int RUN_W = RUN_W_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [SYM_W-1:0] in_sym;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SYM_W-1:0] out_sym;
  logic [RUN_W-1:0] out_run;
  logic             out_last;
  modport master (
    output in_valid, in_sym, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_run, out_last
  );
  modport slave (
    input  in_valid, in_sym, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_run, out_last
  );
endinterface

// File: rtl/rle_token_reg.sv
// rle_token_reg: single-entry valid/ready register holding one output token
module rle_token_reg #(
  parameter int SYM_W = 4,
  parameter int RUN_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [SYM_W+RUN_W:0]   din,
  input  logic                   out_ready,
  output logic                   valid,
  output logic [SYM_W+RUN_W:0]   dout,
  output logic                   slot_free
);
  assign slot_free = !valid | out_ready;
  // load only happens when the slot is free; otherwise hold until delivered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (out_ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/rle_stream_encoder.sv
// rle_stream_encoder: streaming run-length encoder producing {symbol, run, last} tokens
module rle_stream_encoder import rle_pkg::*; #(
  parameter int SYM_W = SYM_W_DEF,
  parameter int RUN_W = RUN_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  rle_stream_encoder_if.slave  bus,
  output logic [15:0]          tok_count
);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(run_max(RUN_W));
  typedef struct packed {
    logic [SYM_W-1:0] sym;
    logic [RUN_W-1:0] run;
    logic             last;
  } tok_t;
  state_t           state, nxt_state;
  logic [SYM_W-1:0] cur_sym, nxt_sym;
  logic [RUN_W-1:0] cur_cnt, nxt_cnt;
  tok_t             tok, out_tok;
  logic             emit, slot_free, acc;
  assign bus.in_ready = slot_free & (state != ST_FLUSH) & !reset;
  assign acc          = bus.in_valid & bus.in_ready;
  assign bus.out_sym  = out_tok.sym;
  assign bus.out_run  = out_tok.run;
  assign bus.out_last = out_tok.last;
  rle_token_reg #(.SYM_W(SYM_W), .RUN_W(RUN_W)) u_tok (
    .clk       (clk),
    .reset     (reset),
    .load      (emit),
    .din       (tok),
    .out_ready (bus.out_ready),
    .valid     (bus.out_valid),
    .dout      (out_tok),
    .slot_free (slot_free)
  );
  // next run state and the token (if any) produced this cycle; a saturated
  // run shares the symbol-change path since both close the run and restart at 1
  always_comb begin
    emit      = 1'b0;
    tok       = '0;
    nxt_state = state;
    nxt_sym   = cur_sym;
    nxt_cnt   = cur_cnt;
    if (state == ST_FLUSH) begin
      emit      = slot_free;
      tok       = {cur_sym, cur_cnt, 1'b1};
      nxt_state = slot_free ? ST_IDLE : ST_FLUSH;
    end else if (acc) begin
      if (state == ST_IDLE) begin
        emit      = bus.in_last;
        tok       = {bus.in_sym, RUN_W'(1), 1'b1};
        nxt_sym   = bus.in_sym;
        nxt_cnt   = RUN_W'(1);
        nxt_state = bus.in_last ? ST_IDLE : ST_RUN;
      end else if (bus.in_sym == cur_sym && cur_cnt != RUN_MAX) begin
        emit      = bus.in_last;
        tok       = {cur_sym, RUN_W'(cur_cnt + 1'b1), 1'b1};
        nxt_cnt   = RUN_W'(cur_cnt + 1'b1);
        nxt_state = bus.in_last ? ST_IDLE : ST_RUN;
      end else begin
        emit      = 1'b1;
        tok       = {cur_sym, cur_cnt, 1'b0};
        nxt_sym   = bus.in_sym;
        nxt_cnt   = RUN_W'(1);
        nxt_state = bus.in_last ? ST_FLUSH : ST_RUN;
      end
    end
  end
  // run FSM registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cur_sym <= '0;
      cur_cnt <= '0;
    end else begin
      state   <= nxt_state;
      cur_sym <= nxt_sym;
      cur_cnt <= nxt_cnt;
    end
  end
  // count delivered tokens, wrapping naturally at 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tok_count <= '0;
    else if (bus.out_valid && bus.out_ready) tok_count <= tok_count + 16'd1;
  end
endmodule

// File: tb/tb_rle_stream_encoder.sv
// tb_rle_stream_encoder: directed and randomized checks of the run-length encoder
module tb_rle_stream_encoder;
  import rle_pkg::*;
  typedef struct {
    logic [3:0] sym;
    logic       last;
  } beat_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] tok_count;
  int          nchk = 0;
  int          nerr = 0;
  token_t      got[$];
  token_t      exp_q[$];
  beat_t       sent[$];
  rle_stream_encoder_if #(.SYM_W(4), .RUN_W(4)) bus();
  rle_stream_encoder #(.SYM_W(4), .RUN_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .tok_count (tok_count)
  );
  always #5 clk = ~clk;
  // record handshakes mid-cycle; they complete on the following rising edge
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) got.push_back('{bus.out_sym, bus.out_run, bus.out_last});
      if (bus.in_valid && bus.in_ready) sent.push_back('{bus.in_sym, bus.in_last});
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] s, input logic l);
    bus.in_valid = 1'b1;
    bus.in_sym   = s;
    bus.in_last  = l;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        step();
        bus.in_valid = 1'b0;
        return;
      end
    end
    nchk++; nerr++;
    $display("FAIL send_timeout: in_ready stayed 0 for sym %0d, required 1", s);
    bus.in_valid = 1'b0;
  endtask
  // reference: split the accepted beats into maximal equal-symbol runs (a
  // last marker closes a run), then chop each run into RUN_MAX-sized pieces
  function automatic void build_expected();
    int i = 0;
    int rmax = run_max(4);
    exp_q.delete();
    while (i < sent.size()) begin
      int j = i;
      int len;
      while (!sent[j].last && j + 1 < sent.size() && sent[j+1].sym == sent[i].sym) j++;
      len = j - i + 1;
      while (len > rmax) begin
        exp_q.push_back('{sent[i].sym, 4'(rmax), 1'b0});
        len -= rmax;
      end
      exp_q.push_back('{sent[i].sym, 4'(len), sent[j].last});
      i = j + 1;
    end
  endfunction
  task automatic test_reset();
    bus.in_valid = 1'b1; bus.in_sym = 4'd1; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    #3;
    nchk++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
    nchk++; if (bus.out_sym !== 4'd0) begin nerr++; $display("FAIL rst_out_sym: got %0d required 0", bus.out_sym); end
    nchk++; if (bus.out_run !== 4'd0) begin nerr++; $display("FAIL rst_out_run: got %0d required 0", bus.out_run); end
    nchk++; if (bus.out_last !== 1'b0) begin nerr++; $display("FAIL rst_out_last: got %b required 0", bus.out_last); end
    nchk++; if (tok_count !== 16'd0) begin nerr++; $display("FAIL rst_tok_count: got %0d required 0", tok_count); end
    nchk++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready: got %b required 0", bus.in_ready); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask
  task automatic test_basic();
    token_t e[2] = '{'{4'd3, 4'd3, 1'b0}, '{4'd5, 4'd1, 1'b1}};
    logic [15:0] base = tok_count;
    got.delete();
    bus.out_ready = 1'b1;
    repeat (3) send(4'd3, 1'b0);
    nchk++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL basic_no_early_token: out_valid %b required 0", bus.out_valid); end
    send(4'd5, 1'b1);
    repeat (3) step();
    nchk++; if (got.size() != 2) begin nerr++; $display("FAIL basic_count: got %0d tokens required 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      nchk++;
      if (got[i] !== e[i]) begin nerr++; $display("FAIL basic_tok%0d: got {%0d,%0d,%0d} required {%0d,%0d,%0d}", i, got[i].sym, got[i].run, got[i].last, e[i].sym, e[i].run, e[i].last); end
    end
    nchk++; if (tok_count !== 16'(base + 2)) begin nerr++; $display("FAIL basic_tok_count: got %0d required %0d", tok_count, 16'(base + 2)); end
  endtask
  task automatic test_saturate();
    token_t e[2] = '{'{4'd7, 4'd15, 1'b0}, '{4'd7, 4'd3, 1'b1}};
    got.delete();
    repeat (17) send(4'd7, 1'b0);
    send(4'd7, 1'b1);
    repeat (3) step();
    nchk++; if (got.size() != 2) begin nerr++; $display("FAIL sat_count: got %0d tokens required 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      nchk++;
      if (got[i] !== e[i]) begin nerr++; $display("FAIL sat_tok%0d: got {%0d,%0d,%0d} required {%0d,%0d,%0d}", i, got[i].sym, got[i].run, got[i].last, e[i].sym, e[i].run, e[i].last); end
      nchk++;
      if (got[i].run == 4'd0) begin nerr++; $display("FAIL sat_run_zero%0d: got 0 required nonzero", i); end
    end
  endtask
  task automatic test_flush();
    send(4'd2, 1'b0);
    send(4'd9, 1'b1);
    nchk++; if ({bus.out_valid, bus.out_sym, bus.out_run, bus.out_last} !== {1'b1, 4'd2, 4'd1, 1'b0}) begin nerr++; $display("FAIL flush_first: got v%b {%0d,%0d,%0d} required v1 {2,1,0}", bus.out_valid, bus.out_sym, bus.out_run, bus.out_last); end
    nchk++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL flush_in_ready: got %b required 0", bus.in_ready); end
    step();
    nchk++; if ({bus.out_valid, bus.out_sym, bus.out_run, bus.out_last} !== {1'b1, 4'd9, 4'd1, 1'b1}) begin nerr++; $display("FAIL flush_second: got v%b {%0d,%0d,%0d} required v1 {9,1,1}", bus.out_valid, bus.out_sym, bus.out_run, bus.out_last); end
    step();
    nchk++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL flush_drained: out_valid %b required 0", bus.out_valid); end
  endtask
  task automatic test_backpressure();
    logic [15:0] base;
    got.delete();
    bus.out_ready = 1'b1;
    send(4'd4, 1'b0);
    bus.out_ready = 1'b0;
    send(4'd6, 1'b0);
    bus.in_valid = 1'b1; bus.in_sym = 4'd6; bus.in_last = 1'b0;
    base = tok_count;
    for (int c = 0; c < 4; c++) begin
      step();
      nchk++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL bp_in_ready%0d: got %b required 0", c, bus.in_ready); end
      nchk++; if ({bus.out_valid, bus.out_sym, bus.out_run, bus.out_last} !== {1'b1, 4'd4, 4'd1, 1'b0}) begin nerr++; $display("FAIL bp_hold%0d: got v%b {%0d,%0d,%0d} required v1 {4,1,0}", c, bus.out_valid, bus.out_sym, bus.out_run, bus.out_last); end
    end
    bus.out_ready = 1'b1;
    #1;
    nchk++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL bp_resume: in_ready %b required 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    nchk++; if (tok_count !== 16'(base + 1)) begin nerr++; $display("FAIL bp_tok_count: got %0d required %0d", tok_count, 16'(base + 1)); end
    send(4'd6, 1'b1);
    repeat (3) step();
    nchk++; if (got.size() != 2) begin nerr++; $display("FAIL bp_count: got %0d tokens required 2", got.size()); end
    else begin
      nchk++; if (got[1] !== token_t'({4'd6, 4'd3, 1'b1})) begin nerr++; $display("FAIL bp_tail: got {%0d,%0d,%0d} required {6,3,1}", got[1].sym, got[1].run, got[1].last); end
    end
  endtask
  task automatic test_async_reset();
    bus.out_ready = 1'b1;
    send(4'd1, 1'b0);
    repeat (6) send(4'd8, 1'b0);
    bus.out_ready = 1'b0;
    send(4'd2, 1'b0);
    nchk++; if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL ar_pending: out_valid %b required 1", bus.out_valid); end
    #2 reset = 1'b1;
    #1;
    nchk++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL ar_out_valid: got %b required 0", bus.out_valid); end
    nchk++; if (tok_count !== 16'd0) begin nerr++; $display("FAIL ar_tok_count: got %0d required 0", tok_count); end
    nchk++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL ar_in_ready: got %b required 0", bus.in_ready); end
    @(negedge clk);
    reset = 1'b0;
    step();
    got.delete(); sent.delete();
    bus.out_ready = 1'b1;
    send(4'd5, 1'b0);
    send(4'd5, 1'b1);
    repeat (3) step();
    nchk++; if (got.size() != 1) begin nerr++; $display("FAIL ar_count: got %0d tokens required 1", got.size()); end
    else begin
      nchk++; if (got[0] !== token_t'({4'd5, 4'd2, 1'b1})) begin nerr++; $display("FAIL ar_clean_run: got {%0d,%0d,%0d} required {5,2,1}", got[0].sym, got[0].run, got[0].last); end
    end
    nchk++; if (tok_count !== 16'd1) begin nerr++; $display("FAIL ar_tok_after: got %0d required 1", tok_count); end
  endtask
  task automatic test_random();
    int          n = 500;
    int          k = 0;
    logic [3:0]  s = 4'd0;
    logic        acc;
    logic [15:0] base = tok_count;
    beat_t       dec[$];
    got.delete(); sent.delete();
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 5000 && k < n; cyc++) begin
      if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 7) == 0) s = 4'($urandom_range(0, 3));
        bus.in_sym   = s;
        bus.in_last  = (k == n - 1) || ($urandom_range(0, 39) == 0);
        bus.in_valid = 1'b1;
      end
      bus.out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) begin
        k++;
        bus.in_valid = 1'b0;
      end
    end
    nchk++; if (k != n) begin nerr++; $display("FAIL rnd_accept: got %0d beats required %0d", k, n); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    build_expected();
    for (int t = 0; t < 100 && got.size() < exp_q.size(); t++) step();
    step();
    nchk++; if (got.size() != exp_q.size()) begin nerr++; $display("FAIL rnd_count: got %0d tokens required %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      nchk++;
      if (got[i] !== exp_q[i]) begin nerr++; $display("FAIL rnd_tok%0d: got {%0d,%0d,%0d} required {%0d,%0d,%0d}", i, got[i].sym, got[i].run, got[i].last, exp_q[i].sym, exp_q[i].run, exp_q[i].last); end
    end
    foreach (got[i]) begin
      if (got[i].run == 4'd0) begin nchk++; nerr++; $display("FAIL rnd_run_zero: token %0d run 0 required nonzero", i); end
      for (int r = 0; r < int'(got[i].run); r++) dec.push_back('{got[i].sym, got[i].last && r == int'(got[i].run) - 1});
    end
    nchk++; if (dec.size() != sent.size()) begin nerr++; $display("FAIL rnd_decode_len: got %0d beats required %0d", dec.size(), sent.size()); end
    for (int i = 0; i < dec.size() && i < sent.size(); i++) begin
      nchk++;
      if (dec[i].sym !== sent[i].sym || dec[i].last !== sent[i].last) begin nerr++; $display("FAIL rnd_decode%0d: got {%0d,%0d} required {%0d,%0d}", i, dec[i].sym, dec[i].last, sent[i].sym, sent[i].last); end
    end
    nchk++; if (tok_count !== 16'(base + got.size())) begin nerr++; $display("FAIL rnd_tok_count: got %0d required %0d", tok_count, 16'(base + got.size())); end
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_sym = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_flush();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
